// File: rtl/exp5_unidade_controle_pkg.sv
// Shared definitions for the exp5 control unit: state codes shown on db_estado
// and the Moore output bundle decoded from them.
package exp5_defs;

  localparam logic [3:0] ST_INICIAL     = 4'h0;
  localparam logic [3:0] ST_PREPARACAO  = 4'h1;
  localparam logic [3:0] ST_ESPERA      = 4'h2;
  localparam logic [3:0] ST_REGISTRA    = 4'h4;
  localparam logic [3:0] ST_COMPARACAO  = 4'h5;
  localparam logic [3:0] ST_PROXIMO     = 4'h6;
  localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] ST_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] ST_FIM_ERRO    = 4'hE;

  typedef enum logic [3:0] {
    INICIAL     = ST_INICIAL,
    PREPARACAO  = ST_PREPARACAO,
    ESPERA      = ST_ESPERA,
    REGISTRA    = ST_REGISTRA,
    COMPARACAO  = ST_COMPARACAO,
    PROXIMO     = ST_PROXIMO,
    FIM_ACERTO  = ST_FIM_ACERTO,
    FIM_TIMEOUT = ST_FIM_TIMEOUT,
    FIM_ERRO    = ST_FIM_ERRO
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Unknown codes decode like INICIAL so the datapath is held cleared.
  function automatic saidas_t decode_saidas(input logic [3:0] estado);
    saidas_t s;
    s = '0;
    case (estado)
      ST_PREPARACAO: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
      ST_ESPERA:      ;
      ST_REGISTRA:    s.registra_r = 1'b1;
      ST_COMPARACAO:  ;
      ST_PROXIMO:     s.conta_c = 1'b1;
      ST_FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      ST_FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      default: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exp5_unidade_controle_timeout.sv
// Play timeout counter: synchronous clear, count enable, and a flag raised
// while the count sits on its last value (TIMEOUT-1). Saturates there.
module contador_timeout #(
  parameter int TIMEOUT   = 5000,
  parameter int TIMEOUT_W = 13
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fim_o
);

  localparam logic [TIMEOUT_W-1:0] ULTIMO = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != ULTIMO)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim_o = (count_q == ULTIMO);

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control unit sequencing exp5_fluxo_dados through one round:
// clear, wait for a play, register it, compare, then advance or finish.
module exp5_unidade_controle
  import exp5_defs::*;
#(
  parameter int TIMEOUT   = 5000,
  parameter int TIMEOUT_W = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t state_q;
  estado_t state_d;
  logic    tmo_fim;
  saidas_t saidas;

  // The counter only runs while waiting; any other state holds it at zero,
  // so every ESPERA visit gets a fresh TIMEOUT-cycle window.
  contador_timeout #(
    .TIMEOUT  (TIMEOUT),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .clk_i (clock),
    .srst_i(reset),
    .clr_i (state_q != ESPERA),
    .en_i  (state_q == ESPERA),
    .fim_o (tmo_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: begin
        if (iniciar) state_d = PREPARACAO;
      end
      PREPARACAO: state_d = ESPERA;
      ESPERA: begin
        // A play arriving on the expiry cycle still counts.
        if (jogada_feita) begin
          state_d = REGISTRA;
        end else if (tmo_fim) begin
          state_d = FIM_TIMEOUT;
        end
      end
      REGISTRA: state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual) begin
          state_d = FIM_ERRO;
        end else if (fimC) begin
          state_d = FIM_ACERTO;
        end else begin
          state_d = PROXIMO;
        end
      end
      PROXIMO: state_d = ESPERA;
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
        if (iniciar) state_d = PREPARACAO;
      end
      default: state_d = INICIAL;
    endcase
  end

  always_comb begin
    saidas = decode_saidas(state_q);
  end

  assign zeraC     = saidas.zera_c;
  assign contaC    = saidas.conta_c;
  assign zeraR     = saidas.zera_r;
  assign registraR = saidas.registra_r;
  assign pronto    = saidas.pronto;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign db_estado = state_q;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle with a small datapath stand-in
// (address counter, play register, 16-word ROM) closing the loop.
module tb_exp5_unidade_controle;
  import exp5_defs::*;

  localparam int TMO = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       igual;
  logic       fimC;
  logic       zeraC, contaC, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  logic [3:0] jogada = 4'h0;
  logic [3:0] rom [16];
  logic [3:0] addr_q = 4'h0;
  logic [3:0] play_q = 4'h0;

  int         checks = 0;
  int         errors = 0;
  int         contaC_cycles = 0;
  logic       chk_en = 1'b0;
  logic [3:0] exp_code = 4'h0;

  always #5 clock = ~clock;

  exp5_unidade_controle #(
    .TIMEOUT  (TMO),
    .TIMEOUT_W(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .jogada_feita(jogada_feita),
    .igual       (igual),
    .fimC        (fimC),
    .zeraC       (zeraC),
    .contaC      (contaC),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .pronto      (pronto),
    .acertou     (acertou),
    .errou       (errou),
    .timeout     (timeout),
    .db_estado   (db_estado)
  );

  // Datapath stand-in: ROM holds 1,2,4,8 repeating.
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
  end

  always @(posedge clock) begin
    if (zeraC) addr_q <= 4'h0;
    else if (contaC) addr_q <= addr_q + 4'h1;
    if (zeraR) play_q <= 4'h0;
    else if (registraR) play_q <= jogada;
  end

  assign igual = (rom[addr_q] == play_q);
  assign fimC  = (addr_q == 4'hF);

  // Output table: {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [7:0] expected_outs(input logic [3:0] code);
    case (code)
      ST_INICIAL, ST_PREPARACAO: return 8'b1010_0000;
      ST_REGISTRA:               return 8'b0001_0000;
      ST_PROXIMO:                return 8'b0100_0000;
      ST_FIM_ACERTO:             return 8'b0000_1100;
      ST_FIM_TIMEOUT:            return 8'b0000_1001;
      ST_FIM_ERRO:               return 8'b0000_1010;
      default:                   return 8'b0000_0000;
    endcase
  endfunction

  // Compare process: every cycle after the first edge, check state and outputs.
  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if (db_estado !== exp_code) begin
        errors++;
        $display("FAIL state: db_estado=%h expected=%h at %0t", db_estado, exp_code, $time);
      end
      checks++;
      if ({zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} !== expected_outs(exp_code)) begin
        errors++;
        $display("FAIL outputs: got=%b expected=%b (state %h) at %0t",
                 {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout},
                 expected_outs(exp_code), exp_code, $time);
      end
      if (contaC) contaC_cycles++;
    end
  end

  task automatic cyc(input logic ini, input logic jf, input logic [3:0] expect_next);
    iniciar      = ini;
    jogada_feita = jf;
    @(posedge clock);
    #1;
    exp_code     = expect_next;
    chk_en       = 1'b1;
    iniciar      = 1'b0;
    jogada_feita = 1'b0;
    $display("cycle t=%0t ini=%b jf=%b jogada=%h -> expect state %h", $time, ini, jf, jogada, expect_next);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, ST_ESPERA);
  endtask

  // One play at round position k; outcome derived from the ROM contents.
  task automatic play(input logic [3:0] v, input int k);
    jogada = v;
    cyc(1'b0, 1'b1, ST_REGISTRA);
    cyc(1'b0, 1'b0, ST_COMPARACAO);
    if (v != rom[k]) begin
      cyc(1'b0, 1'b0, ST_FIM_ERRO);
    end else if (k == 15) begin
      cyc(1'b0, 1'b0, ST_FIM_ACERTO);
    end else begin
      cyc(1'b0, 1'b0, ST_PROXIMO);
      cyc(1'b0, 1'b0, ST_ESPERA);
    end
  endtask

  task automatic check_lit(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, actual, required);
    end
  endtask

  initial begin
    // 1. reset held two cycles, then idle; a play pulse in INICIAL is ignored
    reset = 1'b1;
    cyc(1'b0, 1'b0, ST_INICIAL);
    cyc(1'b0, 1'b0, ST_INICIAL);
    reset = 1'b0;
    cyc(1'b0, 1'b1, ST_INICIAL);
    check_lit("reset_zeraC", int'(zeraC), 1);
    check_lit("reset_pronto", int'(pronto), 0);

    // 2. sixteen correct plays with varying gaps
    contaC_cycles = 0;
    cyc(1'b1, 1'b0, ST_PREPARACAO);
    cyc(1'b0, 1'b0, ST_ESPERA);
    for (int k = 0; k < 16; k++) begin
      idle(k % 3);
      play(rom[k], k);
    end
    check_lit("acerto_state", int'(db_estado), 10);
    check_lit("acerto_contaC_cycles", contaC_cycles, 15);
    check_lit("acerto_contagem", int'(addr_q), 15);
    cyc(1'b0, 1'b0, ST_FIM_ACERTO);
    cyc(1'b0, 1'b1, ST_FIM_ACERTO);

    // 3. plays 1,2,4 correct, fourth play wrong
    cyc(1'b1, 1'b0, ST_PREPARACAO);
    cyc(1'b0, 1'b0, ST_ESPERA);
    play(4'h1, 0);
    play(4'h2, 1);
    play(4'h4, 2);
    play(4'h1, 3);
    check_lit("erro_errou", int'(errou), 1);
    check_lit("erro_contagem", int'(addr_q), 3);
    cyc(1'b0, 1'b0, ST_FIM_ERRO);

    // restart from FIM_ERRO clears the flags and the datapath
    cyc(1'b1, 1'b0, ST_PREPARACAO);
    check_lit("restart_errou", int'(errou), 0);
    cyc(1'b0, 1'b0, ST_ESPERA);

    // 4. no play for TMO cycles in ESPERA
    contaC_cycles = 0;
    idle(TMO - 1);
    cyc(1'b0, 1'b0, ST_FIM_TIMEOUT);
    check_lit("timeout_flag", int'(timeout), 1);
    check_lit("timeout_contaC_cycles", contaC_cycles, 0);
    cyc(1'b0, 1'b0, ST_FIM_TIMEOUT);

    // 5. play on the expiry cycle wins; next ESPERA gets a fresh window
    cyc(1'b1, 1'b0, ST_PREPARACAO);
    cyc(1'b0, 1'b0, ST_ESPERA);
    idle(TMO - 1);
    play(4'h1, 0);
    cyc(1'b1, 1'b0, ST_ESPERA);
    idle(TMO - 2);
    cyc(1'b0, 1'b0, ST_FIM_TIMEOUT);

    // 6. reset mid-round while comparing
    cyc(1'b1, 1'b0, ST_PREPARACAO);
    cyc(1'b0, 1'b0, ST_ESPERA);
    jogada = 4'h1;
    cyc(1'b0, 1'b1, ST_REGISTRA);
    cyc(1'b0, 1'b0, ST_COMPARACAO);
    reset = 1'b1;
    cyc(1'b0, 1'b0, ST_INICIAL);
    reset = 1'b0;
    cyc(1'b0, 1'b0, ST_INICIAL);
    check_lit("midreset_state", int'(db_estado), 0);

    @(negedge clock);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
